// File: rtl/gobou_pkg.sv
// Shared constants and state type for the gobou output path.
package gobou_pkg;
  localparam int DWIDTH     = 16;
  localparam int LWIDTH     = 16;
  localparam int GOBOU_CORE = 16;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} gobou_out_state_t;
endpackage

// File: rtl/gobou_out_writer.sv
// Writes the serializer's word stream to consecutive output-memory addresses.
// Optional negative clamp on the write data: GOBOU_OUT_RELU_EN.
import gobou_pkg::*;

module gobou_out_writer #(
  parameter int CORE   = GOBOU_CORE,
  parameter int AWIDTH = 12
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     req,
  input  logic [AWIDTH-1:0]        out_base,
  input  logic [LWIDTH-1:0]        out_size,
  input  logic                     serial_we,
  input  logic signed [DWIDTH-1:0] in_data,
  input  logic                     relu_en,
  output logic                     mem_we,
  output logic [AWIDTH-1:0]        mem_addr,
  output logic signed [DWIDTH-1:0] mem_wdata,
  output logic                     busy,
  output logic                     ack
);
  localparam int CW = (CORE > 1) ? $clog2(CORE) : 1;

  gobou_out_state_t        state, nstate;
  logic [CW-1:0]           cnt;
  logic [AWIDTH-1:0]       addr;
  logic [LWIDTH-1:0]       remain, remain_nxt;
  logic                    do_wr, last_lane;
  logic signed [DWIDTH-1:0] wdata;

  // Lanes beyond the layer's remaining count are dropped, not written.
  assign do_wr      = (state == SHIFT) && (remain != '0);
  assign remain_nxt = do_wr ? remain - LWIDTH'(1) : remain;
  assign last_lane  = (cnt == CW'(CORE - 1));

`ifdef GOBOU_OUT_RELU_EN
  assign wdata = (relu_en && in_data[DWIDTH-1]) ? '0 : in_data;
`else
  logic unused_relu;
  assign unused_relu = relu_en;
  assign wdata       = in_data;
`endif

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (req) nstate = (out_size == '0) ? DONE : WAIT;
      WAIT:    if (serial_we) nstate = SHIFT;
      SHIFT:   if (last_lane) nstate = (remain_nxt == '0) ? DONE : WAIT;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= IDLE;
    else       state <= nstate;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      cnt       <= '0;
      addr      <= '0;
      remain    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      ack       <= 1'b0;
    end else begin
      mem_we <= do_wr;
      ack    <= (state == DONE);
      // Held through the ack cycle so busy drops only after ack.
      busy   <= (nstate != IDLE) || (state == DONE);
      if (state == IDLE && req) begin
        addr   <= out_base;
        remain <= out_size;
      end
      if (state == WAIT && serial_we) cnt <= '0;
      if (state == SHIFT) begin
        cnt    <= cnt + CW'(1);
        remain <= remain_nxt;
      end
      if (do_wr) begin
        mem_addr  <= addr;
        mem_wdata <= wdata;
        addr      <= addr + AWIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_gobou_out_writer.sv
// Directed bench for gobou_out_writer; the serializer is modelled by driving lane k k+1 cycles after serial_we.
module tb_gobou_out_writer;
  import gobou_pkg::*;
  localparam int CORE   = 16;
  localparam int AWIDTH = 12;

  logic                     clk = 1'b0, xrst = 1'b1, req = 1'b0, serial_we = 1'b0, relu_en = 1'b0;
  logic [AWIDTH-1:0]        out_base = '0;
  logic [LWIDTH-1:0]        out_size = '0;
  logic signed [DWIDTH-1:0] in_data = '0;
  logic                     mem_we, busy, ack;
  logic [AWIDTH-1:0]        mem_addr;
  logic signed [DWIDTH-1:0] mem_wdata;

  int     cyc = 0, n_chk = 0, n_err = 0;
  int     wr_cyc[$], ack_cyc[$];
  longint wr_addr[$], wr_data[$];
  logic signed [DWIDTH-1:0] lane_d [CORE];

  gobou_out_writer #(.CORE(CORE), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .xrst(xrst), .req(req), .out_base(out_base), .out_size(out_size),
    .serial_we(serial_we), .in_data(in_data), .relu_en(relu_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .ack(ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(longint'(mem_addr));
      wr_data.push_back(longint'(mem_wdata));
    end
    if (ack) ack_cyc.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); ack_cyc.delete();
  endtask

  task automatic fill(input int first);
    for (int k = 0; k < CORE; k++) lane_d[k] = DWIDTH'(first + k);
  endtask

  // req in cycle r; returns in cycle r+1 with busy checked.
  task automatic start(input int base, input int size, output int r);
    out_base = AWIDTH'(base); out_size = LWIDTH'(size); req = 1'b1; r = cyc;
    tick(); req = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  // serial_we in cycle t, lane k driven in cycle t+1+k; optional stray req/serial_we mid-SHIFT.
  task automatic send_batch(input bit noise, output int t);
    serial_we = 1'b1; t = cyc;
    tick(); serial_we = 1'b0;
    for (int k = 0; k < CORE; k++) begin
      in_data = lane_d[k];
      if (noise && k == 5) begin
        req = 1'b1; serial_we = 1'b1; out_base = 12'h555; out_size = 3;
      end else begin
        req = 1'b0; serial_we = 1'b0;
      end
      tick();
    end
    in_data = '0;
  endtask

  initial begin
    int r, t, tb[3];
    longint e0;
    // reset state
    #2 xrst = 1'b0; #1;
    chk("rst_we", mem_we, 0); chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0); chk("rst_ack", ack, 0);
    tick(); tick(); xrst = 1'b1; tick();

    // single full batch
    clear_log();
    start(12'h100, 16, r);
    fill(0); send_batch(1'b0, t);
    repeat (4) tick();
    chk("single_n", wr_addr.size(), 16);
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      chk("single_addr", wr_addr[i], 12'h100 + i);
      chk("single_data", wr_data[i], i);
      chk("single_cyc", wr_cyc[i], t + 2 + i);
    end
    chk("single_nack", ack_cyc.size(), 1);
    if (ack_cyc.size() > 0) chk("single_ack_cyc", ack_cyc[0], t + 18);
    chk("single_busy_low", busy, 0);

    // partial last batch: 40 words over three batches
    clear_log();
    start(12'h200, 40, r);
    for (int b = 0; b < 3; b++) begin
      fill(100 * b); send_batch(1'b0, tb[b]);
    end
    repeat (4) tick();
    chk("part_n", wr_addr.size(), 40);
    for (int i = 0; i < 40 && i < wr_addr.size(); i++) begin
      chk("part_addr", wr_addr[i], 12'h200 + i);
      chk("part_data", wr_data[i], 100 * (i / 16) + (i % 16));
      chk("part_cyc", wr_cyc[i], tb[i / 16] + 2 + (i % 16));
    end
    chk("part_nack", ack_cyc.size(), 1);
    if (ack_cyc.size() > 0) chk("part_ack_cyc", ack_cyc[0], tb[2] + CORE + 2);

    // zero size
    clear_log();
    start(12'h080, 0, r);
    tick();
    chk("zero_ack_now", ack, 1);
    tick();
    chk("zero_busy_low", busy, 0);
    fill(50); send_batch(1'b0, t);
    repeat (3) tick();
    chk("zero_nwr", wr_addr.size(), 0);
    chk("zero_nack", ack_cyc.size(), 1);
    if (ack_cyc.size() > 0) chk("zero_ack_cyc", ack_cyc[0], r + 2);

    // relu clamp, enabled then disabled
    for (int pass = 0; pass < 2; pass++) begin
      clear_log();
      relu_en = (pass == 0);
      start(12'h300, 2, r);
      fill(0); lane_d[0] = -16'sd5; lane_d[1] = 16'sd7;
      send_batch(1'b0, t);
      repeat (3) tick();
`ifdef GOBOU_OUT_RELU_EN
      e0 = relu_en ? 0 : -5;
`else
      e0 = -5;
`endif
      chk("relu_n", wr_data.size(), 2);
      if (wr_data.size() == 2) begin
        chk("relu_neg", wr_data[0], e0);
        chk("relu_pos", wr_data[1], 7);
      end
    end
    relu_en = 1'b0;

    // reset in the middle of SHIFT
    clear_log();
    start(12'h400, 16, r);
    serial_we = 1'b1; t = cyc; tick(); serial_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_data = DWIDTH'(k + 1); tick();
    end
    xrst = 1'b0; #1;
    chk("mid_we", mem_we, 0); chk("mid_addr", mem_addr, 0); chk("mid_wdata", mem_wdata, 0);
    chk("mid_busy", busy, 0); chk("mid_ack", ack, 0);
    chk("mid_nwr_before", wr_addr.size(), 5);
    tick(); tick(); xrst = 1'b1; tick();
    clear_log();
    fill(9); send_batch(1'b0, t);
    repeat (3) tick();
    chk("mid_nwr_after", wr_addr.size(), 0);
    chk("mid_nack_after", ack_cyc.size(), 0);

    // address wrap with stray req/serial_we during SHIFT
    clear_log();
    start(12'hFFE, 4, r);
    fill(20); send_batch(1'b1, t);
    repeat (6) tick();
    chk("wrap_n", wr_addr.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      chk("wrap_addr", wr_addr[i], (12'hFFE + i) % 4096);
      chk("wrap_data", wr_data[i], 20 + i);
      chk("wrap_cyc", wr_cyc[i], t + 2 + i);
    end
    chk("wrap_nack", ack_cyc.size(), 1);
    if (ack_cyc.size() > 0) chk("wrap_ack_cyc", ack_cyc[0], t + CORE + 2);
    chk("wrap_busy_low", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
